framebuf_scanout: RTL and testbench

FRAMEBUF_SCANOUT -- requirements
Module: framebuf_scanout

---
 rtl/framebuf_pkg.sv | 6 +
 rtl/framebuf_scanout_fifo.sv | 41 ++++
 rtl/framebuf_scanout.sv | 111 +++++++++++
 tb/tb_framebuf_scanout.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/framebuf_pkg.sv
// framebuf_pkg: shared widths and scan-out state type for the frame buffer scan-out block
package framebuf_pkg;
  localparam int FB_ADDR_W = 13;
  localparam int FB_DATA_W = 16;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} scan_state_t;
endpackage

// File: rtl/framebuf_scanout_fifo.sv
// framebuf_scanout_fifo: synchronous first-word-fall-through FIFO
// Ports: clk, reset (sync, active-high), wr/din push, rd pop, dout = head, full, empty.
// A push while full is taken when a pop happens in the same cycle.
module framebuf_scanout_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic we, re;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign we = wr & (~full | rd);
  assign re = rd & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (we) wp <= wp + 1'b1;
      if (re) rp <= rp + 1'b1;
      cnt <= cnt + CW'(we) - CW'(re);
    end
  end
  always_ff @(posedge clk)
    if (we) mem[wp] <= din;
endmodule

// File: rtl/framebuf_scanout.sv
// framebuf_scanout: fetches one frame from a frame buffer read port and streams it out in slices
// Ports: clk, reset (sync, active-high); frame_start/bank_sel request a frame;
// address2/chipselect2/clken2/write2/byteenable2/writedata2/readdata2 form the read port (data 1 cycle after strobe);
// st_data/st_valid/st_ready/st_sop/st_eop form the output stream; busy and sticky overrun are status.
// Optional: define FRAMEBUF_SCANOUT_DBLBUF_EN to place the latched bank_sel on address2[12].
module framebuf_scanout
  import framebuf_pkg::*;
#(
  parameter int FRAME_WORDS = 8192,
  parameter int SLICE_WORDS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 bank_sel,
  output logic [FB_ADDR_W-1:0] address2,
  output logic                 chipselect2,
  output logic                 clken2,
  output logic                 write2,
  output logic [1:0]           byteenable2,
  output logic [FB_DATA_W-1:0] writedata2,
  input  logic [FB_DATA_W-1:0] readdata2,
  output logic [FB_DATA_W-1:0] st_data,
  output logic                 st_valid,
  input  logic                 st_ready,
  output logic                 st_sop,
  output logic                 st_eop,
  output logic                 busy,
  output logic                 overrun
);
  localparam int CW = 14;
  localparam int UW = $clog2(FIFO_DEPTH) + 1;
  scan_state_t state;
  logic [CW-1:0] n, oidx, sidx;
  logic [FB_ADDR_W-1:0] addr_q;
  logic [UW-1:0] used;
  logic [FB_DATA_W-1:0] head;
  logic cs, rd_vld, bank, ovr, empty, pop, room, start, issue;
  logic unused_full, unused_bits;
  assign pop = ~empty & st_ready;
  // used counts buffered plus in-flight words; a pop this cycle frees a slot for the next read
  assign room = (used < UW'(FIFO_DEPTH)) | pop;
  assign start = frame_start & (state == IDLE);
  assign issue = start | ((state == FETCH) & room);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n <= '0;
      oidx <= '0;
      sidx <= '0;
      addr_q <= '0;
      used <= '0;
      cs <= 1'b0;
      rd_vld <= 1'b0;
      bank <= 1'b0;
      ovr <= 1'b0;
    end else begin
      rd_vld <= cs;
      cs <= issue;
      used <= used + UW'(issue) - UW'(pop);
      ovr <= ovr | (frame_start & (state != IDLE));
      if (issue) begin
        addr_q <= start ? '0 : n[FB_ADDR_W-1:0];
        n <= start ? CW'(1) : n + 1'b1;
      end
      if (start) bank <= bank_sel;
      if (start) begin
        oidx <= '0;
        sidx <= '0;
      end else if (pop) begin
        oidx <= oidx + 1'b1;
        sidx <= (sidx == CW'(SLICE_WORDS - 1)) ? '0 : sidx + 1'b1;
      end
      if (start) state <= FETCH;
      else if ((state == FETCH) & issue & (n == CW'(FRAME_WORDS - 1))) state <= DRAIN;
      else if ((state == DRAIN) & pop & (oidx == CW'(FRAME_WORDS - 1))) state <= IDLE;
    end
  end
  framebuf_scanout_fifo #(.W(FB_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr(rd_vld),
    .din(readdata2),
    .rd(pop),
    .dout(head),
    .full(unused_full),
    .empty(empty)
  );
`ifdef FRAMEBUF_SCANOUT_DBLBUF_EN
  if (FRAME_WORDS > 4096) begin : g_size_chk
    $error("FRAME_WORDS must not exceed 4096 with double buffering");
  end
  assign address2 = {bank, addr_q[11:0]};
  assign unused_bits = addr_q[12];
`else
  assign address2 = addr_q;
  assign unused_bits = bank;
`endif
  assign chipselect2 = cs;
  assign clken2 = cs;
  assign write2 = 1'b0;
  assign byteenable2 = 2'b11;
  assign writedata2 = '0;
  assign st_valid = ~empty;
  assign st_data = empty ? '0 : head;
  assign st_sop = ~empty & (sidx == '0);
  assign st_eop = ~empty & (sidx == CW'(SLICE_WORDS - 1));
  assign busy = state != IDLE;
  assign overrun = ovr;
endmodule

// File: tb/tb_framebuf_scanout.sv
// tb_framebuf_scanout: randomized self-checking bench for framebuf_scanout against a frame-level reference
module tb_framebuf_scanout;
  localparam int FW = 128;
  localparam int SW = 64;
  localparam int DEP = 4;
  logic clk = 1'b0;
  logic reset, frame_start, bank_sel, st_ready;
  logic [12:0] address2;
  logic chipselect2, clken2, write2;
  logic [1:0] byteenable2;
  logic [15:0] writedata2, readdata2, st_data;
  logic st_valid, st_sop, st_eop, busy, overrun;
  logic [15:0] ram [8192];
  int total = 0;
  int bad = 0;
  framebuf_scanout #(.FRAME_WORDS(FW), .SLICE_WORDS(SW), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bank_sel(bank_sel),
    .address2(address2), .chipselect2(chipselect2), .clken2(clken2), .write2(write2),
    .byteenable2(byteenable2), .writedata2(writedata2), .readdata2(readdata2),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop),
    .st_eop(st_eop), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) readdata2 <= chipselect2 ? ram[address2] : 16'hdead;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, st_valid, 0);
    check({tag, "_sop"}, st_sop, 0);
    check({tag, "_eop"}, st_eop, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cs"}, chipselect2, 0);
  endtask
  // mode 0: ready held 1, mode 1: random ready, mode 2: ready low for 20 cycles then 1
  task automatic run_frame(input int mode, input bit bank, input int ov_at, input int abort_at, input bit late);
    int base, k, iss, cyc, first, last;
    bit rdy, ab;
    k = 0; iss = 0; cyc = 0; first = -1; last = -1; ab = 0;
`ifdef FRAMEBUF_SCANOUT_DBLBUF_EN
    base = bank ? 4096 : 0;
`else
    base = 0;
`endif
    frame_start = 1; bank_sel = bank; st_ready = 0;
    step;
    frame_start = 0; bank_sel = 1'($urandom);
    while (k < FW && cyc < 4000 && !ab) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (cyc >= 20);
      st_ready = rdy;
      frame_start = (cyc == ov_at) || (late && st_valid && rdy && k == FW - 1);
      if (k == abort_at) begin
        reset = 1;
        ab = 1;
      end
      @(negedge clk);
      if (cyc < 3) check("latency", st_valid, cyc == 2);
      if (mode == 2 && cyc == 19) check("stall_reads", iss, DEP);
      if (chipselect2) begin
        check("addr", address2, base + iss);
        iss++;
      end
      check("outstanding", (iss - k) <= DEP, 1);
      check("busy", busy, 1);
      if (st_valid) begin
        check("data", st_data, ram[base + k]);
        check("sop", st_sop, (k % SW) == 0);
        check("eop", st_eop, (k % SW) == SW - 1);
        if (rdy) begin
          if (first < 0) first = cyc;
          last = cyc;
          k++;
        end
      end
      step;
      frame_start = 0;
      cyc++;
    end
    if (ab) begin
      @(negedge clk);
      check_quiet("abort");
      check("abort_addr", address2, 0);
      check("abort_ovr", overrun, 0);
      step;
      reset = 0;
      @(negedge clk);
      check("abort_discard", st_valid, 0);
      step;
    end else begin
      check("words", k, FW);
      if (mode == 0) check("throughput", last - first, FW - 1);
      @(negedge clk);
      check_quiet("end");
      step;
    end
  endtask
  initial begin
    reset = 1; frame_start = 0; bank_sel = 0; st_ready = 0;
    for (int i = 0; i < 8192; i++) ram[i] = 16'(i);
    repeat (3) step;
    @(negedge clk);
    check_quiet("reset");
    check("reset_addr", address2, 0);
    check("reset_ovr", overrun, 0);
    check("tie_write", write2, 0);
    check("tie_be", byteenable2, 3);
    check("tie_wdata", writedata2, 0);
    step;
    reset = 0;
    step;
    run_frame(0, 0, -1, -1, 0);
    check("ovr_clean", overrun, 0);
    run_frame(2, 0, -1, -1, 0);
    for (int i = 0; i < 8192; i++) ram[i] = 16'($urandom);
    run_frame(1, 1'($urandom), -1, -1, 0);
    run_frame(2, 1, -1, -1, 0);
    run_frame(0, 0, 10, -1, 0);
    check("ovr_set", overrun, 1);
    run_frame(1, 1, -1, -1, 0);
    check("ovr_sticky", overrun, 1);
    reset = 1;
    step;
    reset = 0;
    @(negedge clk);
    check("ovr_cleared", overrun, 0);
    step;
    run_frame(0, 0, -1, -1, 1);
    check("ovr_late", overrun, 1);
    reset = 1;
    step;
    reset = 0;
    step;
    run_frame(0, 0, -1, 30, 0);
    run_frame(0, 1, -1, -1, 0);
    run_frame(1, 0, -1, -1, 0);
    check("ovr_final", overrun, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
